// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier family.
//   DP_WIDTH_DEF : default operand width
//   S_IDLE/S_ADD/S_SHIFT : one-hot state encodings used by seq_mult_ctrl
package mult_pkg;

  localparam int DP_WIDTH_DEF = 8;

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_ADD   = 3'b010;
  localparam logic [2:0] S_SHIFT = 3'b100;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the add-and-shift multiplier.
//   clock, reset         : rising-edge clock, async active-high reset
//   Start                : operation request, taken only in S_IDLE
//   Q0                   : current multiplier LSB
//   P_is_zero, P_is_one  : iteration counter status
//   Load_regs            : load operands, clear accumulator
//   Add_regs             : write {C,A} with the add/sub result
//   Sub_sel              : last-bit step (subtract in signed mode)
//   Decr_P               : decrement iteration counter
//   Shift_regs           : shift {C,A,Q} right by one
//   Ready                : idle, able to accept Start
//   Done                 : one-cycle pulse on the first idle cycle after a multiply
//
// state   | meaning
// S_IDLE  | waiting for Start, product held
// S_ADD   | conditional add/subtract of B into {C,A}, P decrement
// S_SHIFT | shift {C,A,Q}; return to idle when all bits consumed
module seq_mult_ctrl
  import mult_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic Start,
  input  logic Q0,
  input  logic P_is_zero,
  input  logic P_is_one,
  output logic Load_regs,
  output logic Add_regs,
  output logic Sub_sel,
  output logic Decr_P,
  output logic Shift_regs,
  output logic Ready,
  output logic Done
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Done marks the first idle cycle following the final shift.
      done_q  <= (state_q == S_SHIFT) && P_is_zero;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_ADD;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = P_is_zero ? S_IDLE : S_ADD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Load_regs  = 1'b0;
    Add_regs   = 1'b0;
    Sub_sel    = 1'b0;
    Decr_P     = 1'b0;
    Shift_regs = 1'b0;
    Ready      = 1'b0;
    Done       = done_q;
    case (state_q)
      S_IDLE: begin
        Ready     = 1'b1;
        Load_regs = Start;
      end
      S_ADD: begin
        Add_regs = Q0;
        Sub_sel  = Q0 && P_is_one;
        Decr_P   = 1'b1;
      end
      S_SHIFT: Shift_regs = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_mult_gen2.sv
// Parametrised add-and-shift sequential multiplier, unsigned or two's-complement.
//   clock, reset   : rising-edge clock, async active-high reset
//   Start          : request, accepted while Ready=1
//   Is_signed      : operand/product format, latched on accepted Start
//   Multiplicand   : DP_WIDTH operand, sampled on accepted Start
//   Multiplier     : DP_WIDTH operand, sampled on accepted Start
//   Product        : {A,Q}, valid from Done until the next accepted Start
//   Ready          : idle
//   Done           : one-cycle completion pulse
module seq_mult_gen2
  import mult_pkg::*;
#(
  parameter int DP_WIDTH = DP_WIDTH_DEF,
  parameter int BC_SIZE  = $clog2(DP_WIDTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    Start,
  input  logic                    Is_signed,
  input  logic [DP_WIDTH-1:0]     Multiplicand,
  input  logic [DP_WIDTH-1:0]     Multiplier,
  output logic [2*DP_WIDTH-1:0]   Product,
  output logic                    Ready,
  output logic                    Done
);

  logic [DP_WIDTH-1:0] a_q;
  logic [DP_WIDTH-1:0] q_q;
  logic [DP_WIDTH-1:0] b_q;
  logic                c_q;
  logic [BC_SIZE-1:0]  p_q;
  logic                mode_q;

  logic load_regs, add_regs, sub_sel, decr_p, shift_regs;
  logic p_is_zero, p_is_one;

  logic [DP_WIDTH:0] a_ext;
  logic [DP_WIDTH:0] b_ext;
  logic [DP_WIDTH:0] sum;

  assign p_is_zero = (p_q == '0);
  assign p_is_one  = (p_q == BC_SIZE'(1));

  // Extend to DP_WIDTH+1 so the signed sum never overflows into lost bits.
  assign a_ext = {mode_q & a_q[DP_WIDTH-1], a_q};
  assign b_ext = {mode_q & b_q[DP_WIDTH-1], b_q};
  // In signed mode the multiplier MSB carries weight -2^(N-1), hence subtract.
  assign sum   = (sub_sel && mode_q) ? (a_ext - b_ext) : (a_ext + b_ext);

  seq_mult_ctrl u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .Start      (Start),
    .Q0         (q_q[0]),
    .P_is_zero  (p_is_zero),
    .P_is_one   (p_is_one),
    .Load_regs  (load_regs),
    .Add_regs   (add_regs),
    .Sub_sel    (sub_sel),
    .Decr_P     (decr_p),
    .Shift_regs (shift_regs),
    .Ready      (Ready),
    .Done       (Done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      q_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      p_q    <= '0;
      mode_q <= 1'b0;
    end else begin
      if (load_regs) begin
        b_q    <= Multiplicand;
        q_q    <= Multiplier;
        a_q    <= '0;
        c_q    <= 1'b0;
        p_q    <= BC_SIZE'(DP_WIDTH);
        mode_q <= Is_signed;
      end
      if (add_regs) {c_q, a_q} <= sum;
      if (decr_p) p_q <= p_q - BC_SIZE'(1);
      // Arithmetic shift in signed mode keeps C as the replicated sign.
      if (shift_regs) {c_q, a_q, q_q} <= {mode_q & c_q, c_q, a_q, q_q[DP_WIDTH-1:1]};
    end
  end

  assign Product = {a_q, q_q};

endmodule
